// File: rtl/multiplex_ram_pkg.sv
// Shared slot encoding and timing constants for the time-multiplexed single-port RAM
// and the schedulers that drive it.
package multiplex_ram_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } slot_e;

    // Cycles from a READ-slot address to registered read data on the RAM output.
    localparam int ram_rd_lat_lp = 2;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read/one-write FIFO with first-word-fall-through output and an occupancy count,
// so the producer can do its own credit accounting.
module bsg_fifo_1r1w_small
    import multiplex_ram_pkg::*;
#(
    parameter int width_p = 8,
    parameter int els_p = 4,
    localparam int ptr_width_lp = safe_clog2(els_p),
    localparam int count_width_lp = safe_clog2(els_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      v_i,
    input  logic [width_p-1:0]        data_i,
    output logic                      v_o,
    output logic [width_p-1:0]        data_o,
    input  logic                      yumi_i,
    output logic [count_width_lp-1:0] count_o
);

    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);

    logic [width_p-1:0]        mem_r [els_p];
    logic [ptr_width_lp-1:0]   rd_ptr_r;
    logic [ptr_width_lp-1:0]   wr_ptr_r;
    logic [count_width_lp-1:0] count_r;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == last_ptr_lp) ? {ptr_width_lp{1'b0}} : p + ptr_width_lp'(1'b1);
    endfunction

    assign v_o     = (count_r != {count_width_lp{1'b0}});
    assign data_o  = mem_r[rd_ptr_r];
    assign count_o = count_r;

    // Pointer and occupancy tracking; a push and pop together leave the count unchanged.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_r <= {ptr_width_lp{1'b0}};
            wr_ptr_r <= {ptr_width_lp{1'b0}};
            count_r  <= {count_width_lp{1'b0}};
        end else begin
            if (v_i) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (yumi_i) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({v_i, yumi_i})
                2'b10:   count_r <= count_r + count_width_lp'(1'b1);
                2'b01:   count_r <= count_r - count_width_lp'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage needs no reset: only entries covered by count_r are ever presented.
    always_ff @(posedge clk_i) begin
        if (v_i) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

endmodule

// File: rtl/multiplex_ram_rd_sched.sv
// Read-side scheduler for the time-multiplexed RAM: launches tagged reads in READ slots,
// follows them through the RAM read latency and returns data through a credit-checked FIFO.
module multiplex_ram_rd_sched
    import multiplex_ram_pkg::*;
#(
    parameter int width_p = 16,
    parameter int els_p = 32,
    parameter int tag_width_p = 8,
    parameter int fifo_els_p = 4,
    localparam int addr_width_lp = safe_clog2(els_p)
) (
    input  logic                     mem_clk,
    input  logic                     mem_rst,
    input  logic                     req_val_i,
    input  logic [addr_width_lp-1:0] req_addr_i,
    input  logic [tag_width_p-1:0]   req_tag_i,
    output logic                     req_rdy_o,
    output logic                     ram_r_v_o,
    output logic [addr_width_lp-1:0] ram_r_addr_o,
    input  logic [width_p-1:0]       ram_r_data_i,
    output logic                     resp_val_o,
    output logic [width_p-1:0]       resp_data_o,
    output logic [tag_width_p-1:0]   resp_tag_o,
    input  logic                     resp_rdy_i
);

    localparam int count_width_lp = safe_clog2(fifo_els_p + 1);
    localparam int credit_width_lp = count_width_lp + 1;
    localparam logic [credit_width_lp-1:0] fifo_els_lp = credit_width_lp'(fifo_els_p);

    slot_e                          phase_r;
    logic [1:0]                     inflight_r;
    logic                           pipe_v_r   [ram_rd_lat_lp];
    logic [tag_width_p-1:0]         pipe_tag_r [ram_rd_lat_lp];
    logic [count_width_lp-1:0]      fifo_count_s;
    logic [credit_width_lp-1:0]     occupancy_s;
    logic                           credit_s;
    logic                           issue_s;
    logic                           capture_s;
    logic                           pop_s;
    logic [width_p+tag_width_p-1:0] fifo_data_s;

    // Slot mirror: stays aligned with the RAM only because both leave the same reset together.
    always_ff @(posedge mem_clk) begin
        if (mem_rst) begin
            phase_r <= READ;
        end else begin
            phase_r <= (phase_r == READ) ? WRITE : READ;
        end
    end

    // Reads still in the RAM pipeline already own a FIFO slot, so no capture can overflow.
    assign occupancy_s  = credit_width_lp'(fifo_count_s) + credit_width_lp'(inflight_r);
    assign credit_s     = (occupancy_s < fifo_els_lp);
    assign req_rdy_o    = (phase_r == READ) & credit_s & ~mem_rst;
    assign issue_s      = req_val_i & req_rdy_o;
    assign ram_r_v_o    = issue_s;
    assign ram_r_addr_o = req_addr_i;
    assign capture_s    = pipe_v_r[ram_rd_lat_lp-1];
    assign pop_s        = resp_val_o & resp_rdy_i;

    // Tag pipeline matching the RAM read latency.
    always_ff @(posedge mem_clk) begin
        if (mem_rst) begin
            for (int i = 0; i < ram_rd_lat_lp; i++) begin
                pipe_v_r[i]   <= 1'b0;
                pipe_tag_r[i] <= {tag_width_p{1'b0}};
            end
        end else begin
            pipe_v_r[0]   <= issue_s;
            pipe_tag_r[0] <= req_tag_i;
            for (int i = 1; i < ram_rd_lat_lp; i++) begin
                pipe_v_r[i]   <= pipe_v_r[i-1];
                pipe_tag_r[i] <= pipe_tag_r[i-1];
            end
        end
    end

    // Count of reads launched but not yet captured.
    always_ff @(posedge mem_clk) begin
        if (mem_rst) begin
            inflight_r <= 2'b00;
        end else begin
            case ({issue_s, capture_s})
                2'b10:   inflight_r <= inflight_r + 2'b01;
                2'b01:   inflight_r <= inflight_r - 2'b01;
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    bsg_fifo_1r1w_small #(
        .width_p (width_p + tag_width_p),
        .els_p   (fifo_els_p)
    ) resp_fifo (
        .clk_i   (mem_clk),
        .reset_i (mem_rst),
        .v_i     (capture_s),
        .data_i  ({ram_r_data_i, pipe_tag_r[ram_rd_lat_lp-1]}),
        .v_o     (resp_val_o),
        .data_o  (fifo_data_s),
        .yumi_i  (pop_s),
        .count_o (fifo_count_s)
    );

    assign resp_data_o = fifo_data_s[width_p+tag_width_p-1:tag_width_p];
    assign resp_tag_o  = fifo_data_s[tag_width_p-1:0];

endmodule
